// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the multicycle core: computes the effective address,
// drives a single-outstanding memory access with byte lanes, and extends load data.
module lsu_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  output logic                req_ready,
  input  logic                is_store,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     base,
  input  logic [XLEN-1:0]     offset,
  input  logic [XLEN-1:0]     wdata,
  output logic                done,
  output logic                exc,
  output logic [1:0]          exc_cause,
  output logic [XLEN-1:0]     rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  output logic                mem_read,
  output logic                mem_write,
  input  logic                mem_resp,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic                is_store_q, is_store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [XLEN-1:0]     base_q, base_d;
  logic [XLEN-1:0]     offset_q, offset_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [1:0]          exc_cause_q, exc_cause_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Address-phase decode
  logic [XLEN-1:0]     sum;
  logic [ADDR_W-1:0]   ea;
  logic [LANE_W-1:0]   lane;
  logic [1:0]          size;
  logic [BE_W-1:0]     size_mask;
  logic                misaligned;
  logic                illegal;

  // Load-data path
  logic [XLEN-1:0]     ld_shifted;
  logic [XLEN-1:0]     ld_mask;
  logic                ld_sign_bit;
  logic [XLEN-1:0]     ld_ext;
  logic                timeout_hit;

  always_comb begin
    sum  = base_q + offset_q;
    ea   = sum[ADDR_W-1:0];
    lane = ea[LANE_W-1:0];
    size = funct3_q[1:0];

    size_mask  = '1;
    misaligned = 1'b0;
    case (size)
      2'd0: size_mask = BE_W'(1);
      2'd1: begin size_mask = BE_W'(3);  misaligned = ea[0];     end
      2'd2: begin size_mask = BE_W'(15); misaligned = |ea[1:0];  end
      default: misaligned = |ea[2:0];
    endcase

    if (is_store_q)
      illegal = funct3_q[2] || ((XLEN == 32) && (funct3_q == 3'b011));
    else
      illegal = (funct3_q == 3'b111) ||
                ((XLEN == 32) && ((funct3_q == 3'b011) || (funct3_q == 3'b110)));
  end

  // Loads: bring the addressed lane down to bit 0, then size-mask and extend.
  always_comb begin
    ld_shifted  = mem_rdata >> {lane_q, 3'b000};
    ld_mask     = '1;
    ld_sign_bit = ld_shifted[XLEN-1];
    case (funct3_q[1:0])
      2'd0: begin ld_mask = XLEN'(8'hFF);         ld_sign_bit = ld_shifted[7];  end
      2'd1: begin ld_mask = XLEN'(16'hFFFF);      ld_sign_bit = ld_shifted[15]; end
      2'd2: begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign_bit = ld_shifted[31]; end
      default: ;
    endcase
    if (!funct3_q[2] && ld_sign_bit)
      ld_ext = (ld_shifted & ld_mask) | ~ld_mask;
    else
      ld_ext = ld_shifted & ld_mask;
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    base_d      = base_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    lane_d      = lane_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    rdata_d     = rdata_q;
    exc_cause_d = exc_cause_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          base_d     = base;
          offset_d   = offset;
          wdata_d    = wdata;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        lane_d      = lane;
        mem_addr_d  = {ea[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        mem_wdata_d = wdata_q << {lane, 3'b000};
        if (illegal) begin
          exc_cause_d = 2'd3;
          state_d     = S_ERR;
        end else if (misaligned) begin
          exc_cause_d = 2'd1;
          state_d     = S_ERR;
        end else begin
          mem_be_d    = size_mask << lane;
          mem_read_d  = !is_store_q;
          mem_write_d = is_store_q;
          cnt_d       = CNT_W'(1);
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // A response arriving on the expiry cycle still completes normally.
        if (mem_resp) begin
          if (!is_store_q) rdata_d = ld_ext;
          exc_cause_d = 2'd0;
          mem_be_d    = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_DONE;
        end else if (timeout_hit) begin
          exc_cause_d = 2'd2;
          mem_be_d    = '0;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_ERR;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      wdata_q     <= '0;
      lane_q      <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rdata_q     <= '0;
      exc_cause_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      lane_q      <= lane_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rdata_q     <= rdata_d;
      exc_cause_q <= exc_cause_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign exc       = (state_q == S_ERR);
  assign exc_cause = exc_cause_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl (XLEN=32, TIMEOUT=4) against a byte-level
// reference model of effective address, lanes, extension, traps and latency.
module tb_lsu_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] wdata;
  logic        done;
  logic        exc;
  logic [1:0]  exc_cause;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_read;
  logic        mem_write;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] rdata_exp = '0;

  lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .base(base), .offset(offset),
    .wdata(wdata), .done(done), .exc(exc), .exc_cause(exc_cause),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation: mem_resp is given on ACCESS cycle wait_n+1 (never if past TIMEOUT).
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] off, input logic [31:0] wd,
                       input int unsigned wait_n, input logic [31:0] mrd);
    logic [31:0] ea, exp_be, exp_wd, val;
    logic [7:0]  bytes [4];
    int unsigned nb, lane, exp_cause, exp_lat, exp_strb, acc, lat;
    bit          illegal, seen;

    ea   = b + off;
    lane = ea % 4;
    nb   = 1 << f3[1:0];
    illegal = st ? (f3[2] || f3 == 3'b011)
                 : (f3 == 3'b111 || f3 == 3'b011 || f3 == 3'b110);
    exp_be = ((32'd1 << nb) - 1) << lane;
    exp_wd = wd << (8 * lane);

    if (illegal) begin
      exp_cause = 3; exp_lat = 2; exp_strb = 0;
    end else if (ea % nb != 0) begin
      exp_cause = 1; exp_lat = 2; exp_strb = 0;
    end else if (wait_n + 1 <= TIMEOUT) begin
      exp_cause = 0; exp_lat = wait_n + 3; exp_strb = wait_n + 1;
      if (!st) begin
        for (int i = 0; i < 4; i++) bytes[i] = mrd[8*i +: 8];
        val = '0;
        for (int unsigned i = 0; i < nb; i++) val = val | (32'(bytes[lane + i]) << (8 * i));
        if (!f3[2] && bytes[lane + nb - 1][7])
          for (int unsigned i = nb; i < 4; i++) val = val | (32'hFF << (8 * i));
        rdata_exp = val;
      end
    end else begin
      exp_cause = 2; exp_lat = TIMEOUT + 2; exp_strb = TIMEOUT;
    end

    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; base = b; offset = off; wdata = wd;
    check("req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req = 1'b0;
    is_store = 1'($urandom); funct3 = 3'($urandom);
    base = $urandom; offset = $urandom; wdata = $urandom;

    acc = 0; lat = 0; seen = 0;
    for (int unsigned k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_ready", req_ready, 0);
      if (mem_read || mem_write) begin
        acc++;
        check("strobe_dir", {mem_read, mem_write}, st ? 2'b01 : 2'b10);
        check("mem_addr", mem_addr, ea & ~32'd3);
        check("mem_be", mem_be, exp_be[3:0]);
        if (st) check("mem_wdata", mem_wdata, exp_wd);
        mem_resp  = (acc == wait_n + 1);
        mem_rdata = mem_resp ? mrd : $urandom;
      end else begin
        mem_resp = 1'b0;
        check("be_idle", mem_be, 0);
      end
      if (done) begin
        seen = 1; lat = k; req = 1'b0;
      end else begin
        req = 1'($urandom);
      end
    end
    mem_resp = 1'b0;
    check("done_lat", lat, exp_lat);
    check("exc", exc, exp_cause != 0);
    check("exc_cause", exc_cause, exp_cause);
    check("strobe_cycles", acc, exp_strb);
    check("rdata", rdata, rdata_exp);

    @(negedge clk);
    check("done_pulse", done, 0);
    check("cause_hold", exc_cause, exp_cause);
    check("idle_ready", req_ready, 1);
  endtask

  initial begin
    bit saw_read;
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = '0;
    base = '0; offset = '0; wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_done", done, 0);
    check("rst_exc", exc, 0);
    check("rst_cause", exc_cause, 0);
    check("rst_strobes", {mem_read, mem_write}, 0);
    check("rst_be", mem_be, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ready", req_ready, 1);

    do_op(0, 3'b010, 32'h100, 32'd4, 32'h0, 2, 32'hDEADBEEF);
    do_op(0, 3'b000, 32'h100, 32'd3, 32'h0, 0, 32'h80112233);
    do_op(0, 3'b100, 32'h100, 32'd3, 32'h0, 1, 32'h80112233);
    do_op(1, 3'b001, 32'h100, 32'd2, 32'h1234ABCD, 1, 32'h0);
    do_op(0, 3'b010, 32'h100, 32'd1, 32'h0, 0, 32'h0);
    do_op(0, 3'b111, 32'h100, 32'd0, 32'h0, 0, 32'h0);
    do_op(0, 3'b010, 32'h200, 32'd0, 32'h0, 10, 32'h0);
    do_op(0, 3'b101, 32'h202, 32'd0, 32'h0, 3, 32'h0000C3A5);
    do_op(0, 3'b001, 32'h000, 32'hFFFF_FFFE, 32'h0, 0, 32'h8001_7F00);

    // Reset while ACCESS is in progress with a response pending.
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h300; offset = '0;
    @(posedge clk);
    #1 req = 1'b0;
    saw_read = 0;
    for (int k = 0; k < 10 && !saw_read; k++) begin
      @(negedge clk);
      saw_read = mem_read;
    end
    check("pre_rst_read", saw_read, 1);
    mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA; rst_n = 1'b0;
    @(posedge clk);
    #1;
    rdata_exp = '0;
    check("midrst_strobes", {mem_read, mem_write}, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", req_ready, 1);
    check("midrst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
    end
    do_op(0, 3'b010, 32'h300, 32'd8, 32'h0, 0, 32'h0BAD_F00D);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] b, off;
      b   = 32'h1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      off = 32'($urandom_range(0, 64)) - 32'd32;
      do_op(1'($urandom), 3'($urandom), b, off, $urandom,
            $urandom_range(0, 5), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
